mips_multicycle_controller: RTL and testbench

- Main control FSM for the multicycle 32-bit MIPS core; sits directly upstream of the ALU decoder and drives its 2-bit ALUOp input.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Produces all datapath mux selects and write enables, plus PC enable from the ALU Zero flag.

---
 rtl/mips_ctrl_pkg.sv | 48 ++++
 rtl/mips_multicycle_controller.sv | 148 ++++++++++++++
 tb/tb_mips_multicycle_controller.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller and its ALU decoder.
// MIPS_CTRL_BNE_EN adds the BRANCHNE state for bne support.
package mips_ctrl_pkg;

  localparam int unsigned STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECUTE  = 4'd6,
    ST_ALUWB    = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_ADDIEXEC = 4'd9,
    ST_ADDIWB   = 4'd10,
`ifdef MIPS_CTRL_BNE_EN
    ST_JUMP     = 4'd11,
    ST_BRANCHNE = 4'd12
`else
    ST_JUMP     = 4'd11
`endif
  } ctrl_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_controller.sv
// Main control FSM of the multicycle MIPS core: Moore-decoded datapath controls.
// Define MIPS_CTRL_BNE_EN to route opcode 000101 through the BRANCHNE state.
module mips_multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STATE_WIDTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Ctrl_Opcode,
  input  logic       Ctrl_Zero,
  output logic       Ctrl_IorD,
  output logic       Ctrl_MemWrite,
  output logic       Ctrl_IRWrite,
  output logic       Ctrl_RegDst,
  output logic       Ctrl_MemtoReg,
  output logic       Ctrl_RegWrite,
  output logic       Ctrl_ALUSrcA,
  output logic [1:0] Ctrl_ALUSrcB,
  output logic [1:0] Ctrl_PCSrc,
  output logic [1:0] Ctrl_ALUOp,
  output logic       Ctrl_PCEn
);

  logic [STATE_WIDTH-1:0] state_q;
  ctrl_state_t            state;
  ctrl_state_t            state_next;

  logic       iord, mem_write, ir_write, reg_dst, memto_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src, alu_op;
  logic       pc_write, branch, branch_ne;

  assign state = ctrl_state_t'(state_q);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= STATE_WIDTH'(ST_FETCH);
    else      state_q <= STATE_WIDTH'(state_next);
  end

  always_comb begin
    state_next = ST_FETCH;
    case (state)
      ST_FETCH: state_next = ST_DECODE;
      ST_DECODE: begin
        case (Ctrl_Opcode)
          OP_LW, OP_SW: state_next = ST_MEMADR;
          OP_RTYPE:     state_next = ST_EXECUTE;
          OP_BEQ:       state_next = ST_BRANCH;
          OP_ADDI:      state_next = ST_ADDIEXEC;
          OP_J:         state_next = ST_JUMP;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       state_next = ST_BRANCHNE;
`endif
          default:      state_next = ST_FETCH;
        endcase
      end
      ST_MEMADR: begin
        if (Ctrl_Opcode == OP_LW)      state_next = ST_MEMREAD;
        else if (Ctrl_Opcode == OP_SW) state_next = ST_MEMWRITE;
        else                           state_next = ST_FETCH;
      end
      ST_MEMREAD:  state_next = ST_MEMWB;
      ST_EXECUTE:  state_next = ST_ALUWB;
      ST_ADDIEXEC: state_next = ST_ADDIWB;
      default:     state_next = ST_FETCH;
    endcase
  end

  always_comb begin
    iord      = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_dst   = 1'b0;
    memto_reg = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_REG;
    pc_src    = PCSRC_ALU;
    alu_op    = ALUOP_ADD;
    pc_write  = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    case (state)
      ST_FETCH: begin
        alu_src_b = SRCB_FOUR;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
      end
      ST_DECODE: alu_src_b = SRCB_IMM_SH2;
      ST_MEMADR, ST_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEMREAD: iord = 1'b1;
      ST_MEMWB: begin
        memto_reg = 1'b1;
        reg_write = 1'b1;
      end
      ST_MEMWRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      ST_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
      end
`ifdef MIPS_CTRL_BNE_EN
      ST_BRANCHNE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch_ne = 1'b1;
      end
`endif
      ST_ADDIWB: reg_write = 1'b1;
      ST_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Gate with RST so that reset silences the datapath in the same cycle it is asserted,
  // even though the state register already holds FETCH.
  assign Ctrl_IorD     = RST & iord;
  assign Ctrl_MemWrite = RST & mem_write;
  assign Ctrl_IRWrite  = RST & ir_write;
  assign Ctrl_RegDst   = RST & reg_dst;
  assign Ctrl_MemtoReg = RST & memto_reg;
  assign Ctrl_RegWrite = RST & reg_write;
  assign Ctrl_ALUSrcA  = RST & alu_src_a;
  assign Ctrl_ALUSrcB  = RST ? alu_src_b : 2'b00;
  assign Ctrl_PCSrc    = RST ? pc_src : 2'b00;
  assign Ctrl_ALUOp    = RST ? alu_op : 2'b00;
  assign Ctrl_PCEn     = RST & (pc_write | (branch & Ctrl_Zero) | (branch_ne & ~Ctrl_Zero));

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed, table-driven bench for mips_multicycle_controller (default and MIPS_CTRL_BNE_EN builds).
module tb_mips_multicycle_controller;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [5:0] Ctrl_Opcode = 6'b100011;
  logic       Ctrl_Zero = 1'b0;
  logic       Ctrl_IorD, Ctrl_MemWrite, Ctrl_IRWrite, Ctrl_RegDst, Ctrl_MemtoReg;
  logic       Ctrl_RegWrite, Ctrl_ALUSrcA, Ctrl_PCEn;
  logic [1:0] Ctrl_ALUSrcB, Ctrl_PCSrc, Ctrl_ALUOp;

  mips_multicycle_controller #(.STATE_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .Ctrl_Opcode(Ctrl_Opcode), .Ctrl_Zero(Ctrl_Zero),
    .Ctrl_IorD(Ctrl_IorD), .Ctrl_MemWrite(Ctrl_MemWrite), .Ctrl_IRWrite(Ctrl_IRWrite),
    .Ctrl_RegDst(Ctrl_RegDst), .Ctrl_MemtoReg(Ctrl_MemtoReg), .Ctrl_RegWrite(Ctrl_RegWrite),
    .Ctrl_ALUSrcA(Ctrl_ALUSrcA), .Ctrl_ALUSrcB(Ctrl_ALUSrcB), .Ctrl_PCSrc(Ctrl_PCSrc),
    .Ctrl_ALUOp(Ctrl_ALUOp), .Ctrl_PCEn(Ctrl_PCEn)
  );

  always #5 CLK = ~CLK;

  // {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUOp, PCEn}
  logic [13:0] obs;
  assign obs = {Ctrl_IorD, Ctrl_MemWrite, Ctrl_IRWrite, Ctrl_RegDst, Ctrl_MemtoReg,
                Ctrl_RegWrite, Ctrl_ALUSrcA, Ctrl_ALUSrcB, Ctrl_PCSrc, Ctrl_ALUOp, Ctrl_PCEn};

  localparam logic [13:0] E_ZERO     = 14'b0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [13:0] E_FETCH    = 14'b0_0_1_0_0_0_0_01_00_00_1;
  localparam logic [13:0] E_DECODE   = 14'b0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [13:0] E_MEMADR   = 14'b0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [13:0] E_MEMREAD  = 14'b1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [13:0] E_MEMWB    = 14'b0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [13:0] E_MEMWRITE = 14'b1_1_0_0_0_0_0_00_00_00_0;
  localparam logic [13:0] E_EXECUTE  = 14'b0_0_0_0_0_0_1_00_00_10_0;
  localparam logic [13:0] E_ALUWB    = 14'b0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [13:0] E_BR_TAKEN = 14'b0_0_0_0_0_0_1_00_01_01_1;
  localparam logic [13:0] E_BR_NOT   = 14'b0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [13:0] E_ADDIEX   = 14'b0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [13:0] E_ADDIWB   = 14'b0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [13:0] E_JUMP     = 14'b0_0_0_0_0_0_0_00_10_00_1;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        zero;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  initial begin
    // lw, with opcode churn in FETCH and MEMREAD that must be ignored
    vecs.push_back('{"lw_fetch",    6'b111111, 1'b0, E_FETCH});
    vecs.push_back('{"lw_decode",   6'b100011, 1'b1, E_DECODE});
    vecs.push_back('{"lw_memadr",   6'b100011, 1'b0, E_MEMADR});
    vecs.push_back('{"lw_memread",  6'b000000, 1'b1, E_MEMREAD});
    vecs.push_back('{"lw_memwb",    6'b000100, 1'b0, E_MEMWB});
    vecs.push_back('{"sw_fetch",    6'b000010, 1'b1, E_FETCH});
    vecs.push_back('{"sw_decode",   6'b101011, 1'b0, E_DECODE});
    vecs.push_back('{"sw_memadr",   6'b101011, 1'b0, E_MEMADR});
    vecs.push_back('{"sw_memwrite", 6'b100011, 1'b0, E_MEMWRITE});
    vecs.push_back('{"r_fetch",     6'b101011, 1'b0, E_FETCH});
    vecs.push_back('{"r_decode",    6'b000000, 1'b0, E_DECODE});
    vecs.push_back('{"r_execute",   6'b001000, 1'b1, E_EXECUTE});
    vecs.push_back('{"r_aluwb",     6'b001000, 1'b0, E_ALUWB});
    vecs.push_back('{"addi_fetch",  6'b000000, 1'b0, E_FETCH});
    vecs.push_back('{"addi_decode", 6'b001000, 1'b0, E_DECODE});
    vecs.push_back('{"addi_exec",   6'b100011, 1'b0, E_ADDIEX});
    vecs.push_back('{"addi_wb",     6'b000000, 1'b0, E_ADDIWB});
    vecs.push_back('{"beqt_fetch",  6'b000000, 1'b0, E_FETCH});
    vecs.push_back('{"beqt_decode", 6'b000100, 1'b0, E_DECODE});
    vecs.push_back('{"beqt_branch", 6'b000100, 1'b1, E_BR_TAKEN});
    vecs.push_back('{"beqn_fetch",  6'b000000, 1'b0, E_FETCH});
    vecs.push_back('{"beqn_decode", 6'b000100, 1'b1, E_DECODE});
    vecs.push_back('{"beqn_branch", 6'b000100, 1'b0, E_BR_NOT});
    vecs.push_back('{"j_fetch",     6'b000100, 1'b0, E_FETCH});
    vecs.push_back('{"j_decode",    6'b000010, 1'b1, E_DECODE});
    vecs.push_back('{"j_jump",      6'b000010, 1'b0, E_JUMP});
    vecs.push_back('{"ill_fetch",   6'b000000, 1'b0, E_FETCH});
    vecs.push_back('{"ill_decode",  6'b111111, 1'b0, E_DECODE});
    vecs.push_back('{"ill_refetch", 6'b000101, 1'b0, E_FETCH});
    vecs.push_back('{"bne_decode",  6'b000101, 1'b0, E_DECODE});
`ifdef MIPS_CTRL_BNE_EN
    vecs.push_back('{"bne_branch",  6'b000000, 1'b0, E_BR_TAKEN});
    vecs.push_back('{"bne_fetch",   6'b000000, 1'b1, E_FETCH});
`else
    vecs.push_back('{"bne_refetch", 6'b000000, 1'b0, E_FETCH});
`endif
    vecs.push_back('{"end_decode",  6'b111110, 1'b0, E_DECODE});
    vecs.push_back('{"end_fetch",   6'b000000, 1'b0, E_FETCH});

    // Reset held across clock edges with lw on the opcode bus
    repeat (2) @(negedge CLK);
    #1 check("reset_hold_a", obs, E_ZERO);
    @(negedge CLK);
    Ctrl_Zero = 1'b1;
    #1 check("reset_hold_b", obs, E_ZERO);

    @(negedge CLK);
    RST = 1'b1;
    for (int unsigned i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge CLK);
      Ctrl_Opcode = vecs[i].op;
      Ctrl_Zero   = vecs[i].zero;
      #1 check(vecs[i].name, obs, vecs[i].exp);
    end

    // Reset asserted during MEMWRITE of an sw
    @(negedge CLK);
    Ctrl_Opcode = 6'b101011;
    #1 check("msw_decode", obs, E_DECODE);
    @(negedge CLK);
    #1 check("msw_memadr", obs, E_MEMADR);
    @(negedge CLK);
    #1 check("msw_memwrite", obs, E_MEMWRITE);
    #1 RST = 1'b0;
    #1 check("msw_abort", obs, E_ZERO);
    @(posedge CLK);
    #1 check("msw_abort_edge", obs, E_ZERO);
    @(negedge CLK);
    RST = 1'b1;
    Ctrl_Opcode = 6'b000010;
    #1 check("msw_restart_fetch", obs, E_FETCH);
    @(negedge CLK);
    #1 check("msw_restart_decode", obs, E_DECODE);
    @(negedge CLK);
    #1 check("msw_restart_jump", obs, E_JUMP);
    @(negedge CLK);
    #1 check("msw_restart_refetch", obs, E_FETCH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
